sprite_select_gen: RTL
======================

SPRITE_SELECT_GEN -- requirements
Module: sprite_select_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, giving the active pixels per line, legal range 2..1023.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port wr_en, input, 1 bit: strobe that writes one sprite descriptor.
REQ-005 The block SHALL have port wr_idx, input, 4 bits: index of the sprite slot to write.
REQ-006 The block SHALL have port wr_xpos, input, 10 bits: left pixel column of the sprite.
REQ-007 The block SHALL have port wr_act, input, 1 bit: sprite-enabled flag.
REQ-008 The block SHALL have port line_start, input, 1 bit: single-cycle pulse that begins a scan line.
REQ-009 The block SHALL have port select, output, 16 bits: one-hot sprite select that feeds the 16-channel 32-bit one-hot mux.
REQ-010 The block SHALL have port col, output, 5 bits: bit index into the selected sprite's 32-bit row word.
REQ-011 The block SHALL have port pix_x, output, 10 bits: pixel column aligned with select and col.
REQ-012 The block SHALL have port sel_valid, output, 1 bit: high when select, col and pix_x describe an active pixel.
REQ-013 The block SHALL have port collide, output, 1 bit, present only under SPRITE_COLLIDE_EN (REQ-028).

Function
REQ-014 The block SHALL hold 16 descriptors {xpos[9:0], act}; a wr_en edge updates slot wr_idx, and the new value first affects the hit evaluation of the following cycle.
REQ-015 The block SHALL hold an internal pixel counter x[9:0] and an active flag; line_start loads x=0 and active=1 at the edge.
REQ-016 While active, x SHALL increment by 1 each cycle; after the cycle with x==H_ACTIVE-1, active clears and x holds.
REQ-017 line_start arriving while active SHALL restart the line at x=0, with no gap cycle.
REQ-018 Hit_i SHALL be act_i && x>=xpos_i && x<xpos_i+32, computed at 11-bit width with no wrap, so a sprite past column 1023 is clipped.
REQ-019 The block SHALL produce a winner equal to the lowest-index hit (slot 0 has highest priority).
REQ-020 select SHALL be the one-hot code of the winner, and all zeros when there is no hit or active=0; select never has more than one bit set.
REQ-021 col SHALL be (x - xpos_winner)[4:0] and 0 when there is no winner.
REQ-022 Latency SHALL be one cycle: select, col, pix_x and sel_valid at cycle t+1 reflect x and active at cycle t.
REQ-023 sel_valid SHALL equal the registered active flag, independent of whether a hit exists.
REQ-024 A write to the winning slot in the same cycle SHALL NOT alter that cycle's output; the old descriptor is used.

Reset
REQ-025 reset_n low SHALL immediately clear all descriptors (xpos=0, act=0), x=0, active=0, select=0, col=0, pix_x=0, sel_valid=0 and collide=0.
REQ-026 Reset asserted mid-line SHALL abort the line; after release, outputs stay 0 until the next line_start.
REQ-027 The first edge after reset_n deasserts SHALL be a normal functional edge; it accepts wr_en and line_start.

Configuration
REQ-028 With macro SPRITE_COLLIDE_EN defined, collide SHALL be a sticky flag set one cycle after any active pixel with two or more hits, and cleared by line_start.
REQ-029 When line_start and a collision coincide, the clear SHALL win and that collision SHALL be discarded.
REQ-030 Without SPRITE_COLLIDE_EN, the collide port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 The bench SHALL cover single sprite: slot 3 xpos=100 act=1, line_start -> select=0x0008 exactly for pix_x 100..131, col 0..31, else 0.
REQ-032 The bench SHALL cover priority overlap: slot 2 xpos=50, slot 9 xpos=60 -> pix_x 60..81 select=0x0004; pix_x 82..91 select=0x0200, col 22..31; collide=1 from pix_x 60 (macro on).
REQ-033 The bench SHALL cover edge clip and line end with H_ACTIVE=640: slot 0 xpos=630 -> select=0x0001 for pix_x 630..639; sel_valid drops after pix_x=639.
REQ-034 The bench SHALL cover restart and write hazard: line_start at x=200 -> next pix_x=0; a write of slot 3 act=0 at x=110 -> output at pix_x 110 still 0x0008, at 111 0x0000.
REQ-035 The bench SHALL cover mid-line reset: reset_n low at x=300 -> all outputs 0 immediately, still 0 after release until line_start; descriptors read back inactive.

Source files
------------

// File: rtl/sprite_select_gen.sv
// rtl/sprite_select_gen.sv - per-pixel sprite hit detection and one-hot select generator
//
// Purpose:
//   Holds 16 sprite descriptors {xpos, act}, runs a pixel counter across each
//   active scan line and, one cycle later, emits a one-hot select of the
//   lowest-index sprite covering the current pixel together with the bit
//   index into that sprite's 32-bit row word.
//
// Optional feature:
//   SPRITE_COLLIDE_EN - when defined, adds the sticky collide output that
//   flags any active pixel covered by two or more sprites on the current line.
//
// Ports:
//   clk         in   clock, all state changes on its rising edge
//   reset_n     in   asynchronous active-low reset
//   wr_en       in   write strobe for one sprite descriptor
//   wr_idx      in   [3:0] descriptor slot to write
//   wr_xpos     in   [9:0] left pixel column of the sprite
//   wr_act      in   sprite enable flag
//   line_start  in   single-cycle pulse that (re)starts a scan line
//   select      out  [15:0] one-hot sprite select, zero when no hit
//   col         out  [4:0] bit index into the selected sprite's row word
//   pix_x       out  [9:0] pixel column aligned with select/col
//   sel_valid   out  high while select/col/pix_x describe an active pixel
//   collide     out  sticky multi-sprite overlap flag (SPRITE_COLLIDE_EN only)

module sprite_select_gen #(
  parameter int H_ACTIVE = 640
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [9:0]  wr_xpos,
  input  logic        wr_act,
  input  logic        line_start,
  output logic [15:0] select,
  output logic [4:0]  col,
  output logic [9:0]  pix_x,
`ifdef SPRITE_COLLIDE_EN
  output logic        collide,
`endif
  output logic        sel_valid
);

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);

  // Descriptor storage
  logic [9:0]  xpos_q [16];
  logic [15:0] act_q;

  // Pixel counter state
  logic [9:0]  x_q;
  logic        active_q;

  // Registered outputs and their next-state values
  logic [15:0] select_q, select_d;
  logic [4:0]  col_q,    col_d;
  logic [9:0]  pix_x_q,  pix_x_d;
  logic        valid_q;

  // Hit evaluation
  logic [15:0] hit;
  logic        found;
  logic [3:0]  win_idx;
  logic        multi_hit;

  // A sprite covers columns xpos..xpos+31. The comparison is done at 11 bits
  // so a sprite near column 1023 is clipped rather than wrapping to column 0.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      hit[i] = act_q[i]
               && ({1'b0, x_q} >= {1'b0, xpos_q[i]})
               && ({1'b0, x_q} <  ({1'b0, xpos_q[i]} + 11'd32));
    end
  end

  // Lowest index wins.
  always_comb begin
    found   = 1'b0;
    win_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (hit[i] && !found) begin
        found   = 1'b1;
        win_idx = 4'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_hit = |(hit & (hit - 16'd1));

  always_comb begin
    select_d = 16'd0;
    col_d    = 5'd0;
    pix_x_d  = 10'd0;
    if (active_q) begin
      pix_x_d = x_q;
      if (found) begin
        select_d = 16'd1 << win_idx;
        // Only the low five bits of the offset matter, so subtract at 5 bits.
        col_d    = x_q[4:0] - xpos_q[win_idx][4:0];
      end
    end
  end

  // Descriptor writes land at the edge, so the hit logic of the current cycle
  // still sees the old descriptor and the new one applies from the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        xpos_q[i] <= 10'd0;
      end
      act_q <= 16'd0;
    end else if (wr_en) begin
      xpos_q[wr_idx] <= wr_xpos;
      act_q[wr_idx]  <= wr_act;
    end
  end

  // Pixel counter: line_start always restarts at column 0, even mid-line.
  // After the last column the counter holds and active drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= 10'd0;
      active_q <= 1'b0;
    end else if (line_start) begin
      x_q      <= 10'd0;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (x_q == X_LAST) begin
        active_q <= 1'b0;
      end else begin
        x_q <= x_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      select_q <= 16'd0;
      col_q    <= 5'd0;
      pix_x_q  <= 10'd0;
      valid_q  <= 1'b0;
    end else begin
      select_q <= select_d;
      col_q    <= col_d;
      pix_x_q  <= pix_x_d;
      valid_q  <= active_q;
    end
  end

  assign select    = select_q;
  assign col       = col_q;
  assign pix_x     = pix_x_q;
  assign sel_valid = valid_q;

`ifdef SPRITE_COLLIDE_EN
  logic collide_q;

  // line_start has priority: a collision in the same cycle is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      collide_q <= 1'b0;
    end else if (line_start) begin
      collide_q <= 1'b0;
    end else if (active_q && multi_hit) begin
      collide_q <= 1'b1;
    end
  end

  assign collide = collide_q;
`else
  logic unused_multi_hit;
  assign unused_multi_hit = multi_hit;
`endif

endmodule
